// File: rtl/seq_cmp_pkg.sv
// Shared types and elaboration helpers for the sequential magnitude comparator.
package seq_cmp_pkg;

    // Controller states: waiting for a request, scanning slices, reporting a result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    // Width of the slice index for n slices: clog2(n), never less than 1 bit.
    function automatic int idx_w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

    // Legal geometry: operands split into a whole number of DIGIT-bit slices.
    function automatic bit slices_ok(input int width, input int digit);
        return (width >= 2) && (digit >= 1) && (digit <= width) && ((width % digit) == 0);
    endfunction

endpackage

// File: rtl/seq_mag_comparator_digit_cmp.sv
// Combinational compare of one DIGIT-bit slice, treated as unsigned.
module digit_cmp
    import seq_cmp_pkg::*;
#(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    output logic             gt_o,
    output logic             lt_o
);

    // Unsigned magnitude relation of the two slices.
    always_comb begin
        gt_o = (a_i > b_i);
        lt_o = (a_i < b_i);
    end

endmodule

// File: rtl/seq_mag_comparator.sv
// Multi-cycle MSB-first magnitude comparator with start/busy/done handshake.
// Latched operands shift left one slice per SCAN cycle so the slice under
// test always sits at the top; the scan stops on the first differing slice.
module seq_mag_comparator
    import seq_cmp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             Greater,
    output logic             Smaller,
    output logic             Equal
);

    localparam int N  = WIDTH / DIGIT;
    localparam int KW = idx_w(N);
    localparam logic [KW-1:0]    K_LAST   = KW'(N - 1);
    // Two's-complement order equals unsigned order once the sign bit is inverted.
    localparam logic [DIGIT-1:0] MSB_MASK = DIGIT'(1) << (DIGIT - 1);

    if (!slices_ok(WIDTH, DIGIT)) begin : g_bad_geometry
        $error("seq_mag_comparator: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    state_e           state_q;
    logic [KW-1:0]    k_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             sgn_q;
    logic             busy_q;
    logic             done_q;
    logic             gt_q;
    logic             lt_q;
    logic             eq_q;

    logic [DIGIT-1:0] slice_a;
    logic [DIGIT-1:0] slice_b;
    logic             slice_gt;
    logic             slice_lt;
    logic             accept;
    logic             finish;

    // Current top slice, sign-adjusted on slice 0; decide accept and scan end.
    always_comb begin
        slice_a = a_q[WIDTH-1 -: DIGIT];
        slice_b = b_q[WIDTH-1 -: DIGIT];
        if (sgn_q && (k_q == '0)) begin
            slice_a = slice_a ^ MSB_MASK;
            slice_b = slice_b ^ MSB_MASK;
        end
        accept = start && (state_q != SCAN);
        finish = (state_q == SCAN) && (slice_gt || slice_lt || (k_q == K_LAST));
    end

    digit_cmp #(
        .DIGIT (DIGIT)
    ) u_digit_cmp (
        .a_i  (slice_a),
        .b_i  (slice_b),
        .gt_o (slice_gt),
        .lt_o (slice_lt)
    );

    // Operand registers: load on accept, shift the next slice up while scanning.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q   <= A;
            b_q   <= B;
            sgn_q <= signed_mode;
        end else if ((state_q == SCAN) && !finish) begin
            a_q <= a_q << DIGIT;
            b_q <= b_q << DIGIT;
        end
    end

    // Controller, slice counter and registered result/handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= SCAN;
                        busy_q  <= 1'b1;
                        k_q     <= '0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SCAN: begin
                    if (finish) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        gt_q    <= slice_gt;
                        lt_q    <= slice_lt;
                        eq_q    <= !(slice_gt || slice_lt);
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign Greater = gt_q;
    assign Smaller = lt_q;
    assign Equal   = eq_q;

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Bench for seq_mag_comparator: three geometries (16/2, 8/8, 8/1) against an
// arithmetic reference of the compare result and first-differing-slice latency.
module tb_seq_mag_comparator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        st [3];
    logic        sm [3];
    logic [15:0] av [3];
    logic [15:0] bv [3];
    logic        by [3];
    logic        dn [3];
    logic        gt [3];
    logic        lt [3];
    logic        eq [3];

    logic        pg [3];
    logic        pl [3];
    logic        pe [3];

    int n_run  = 0;
    int n_fail = 0;

    logic [15:0] b2b_a [3] = '{16'h8000, 16'h0100, 16'h0000};
    logic [15:0] b2b_b [3] = '{16'h0000, 16'h0000, 16'h0001};

    seq_mag_comparator #(.WIDTH(16), .DIGIT(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .signed_mode(sm[0]),
        .A(av[0]), .B(bv[0]), .busy(by[0]), .done(dn[0]),
        .Greater(gt[0]), .Smaller(lt[0]), .Equal(eq[0])
    );

    seq_mag_comparator #(.WIDTH(8), .DIGIT(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .signed_mode(sm[1]),
        .A(av[1][7:0]), .B(bv[1][7:0]), .busy(by[1]), .done(dn[1]),
        .Greater(gt[1]), .Smaller(lt[1]), .Equal(eq[1])
    );

    seq_mag_comparator #(.WIDTH(8), .DIGIT(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(st[2]), .signed_mode(sm[2]),
        .A(av[2][7:0]), .B(bv[2][7:0]), .busy(by[2]), .done(dn[2]),
        .Greater(gt[2]), .Smaller(lt[2]), .Equal(eq[2])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int width_of(input int d);
        return (d == 0) ? 16 : 8;
    endfunction

    function automatic int digit_of(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 8 : 1);
    endfunction

    // Index of the first MSB-first slice where the operands differ, N if none.
    function automatic int first_diff(input int d, input logic [15:0] a, input logic [15:0] b);
        int w, g, n, m, ai, bi;
        w  = width_of(d);
        g  = digit_of(d);
        n  = w / g;
        m  = (1 << g) - 1;
        ai = int'(a) & ((1 << w) - 1);
        bi = int'(b) & ((1 << w) - 1);
        for (int j = 0; j < n; j++) begin
            if (((ai >> (w - (j + 1) * g)) & m) != ((bi >> (w - (j + 1) * g)) & m)) return j;
        end
        return n;
    endfunction

    function automatic int exp_latency(input int d, input logic [15:0] a, input logic [15:0] b);
        int n, fd;
        n  = width_of(d) / digit_of(d);
        fd = first_diff(d, a, b);
        return (fd == n) ? n : fd + 1;
    endfunction

    // Numeric value of an operand under the chosen interpretation.
    function automatic int sval(input int d, input logic [15:0] a, input logic s);
        int w, v;
        w = width_of(d);
        v = int'(a) & ((1 << w) - 1);
        if (s && (v >= (1 << (w - 1)))) v = v - (1 << w);
        return v;
    endfunction

    function automatic logic [2:0] exp_result(input int d, input logic [15:0] a,
                                              input logic [15:0] b, input logic s);
        int va, vb;
        va = sval(d, a, s);
        vb = sval(d, b, s);
        return {va > vb, va < vb, va == vb};
    endfunction

    task automatic wait_done(input int d, input string tag, output int c);
        c = 0;
        do begin
            @(posedge clk);
            #1;
            c++;
        end while (!dn[d] && (c < 40));
        if (!dn[d]) chk($sformatf("%s.timeout", tag), 32'(dn[d]), 32'd1);
    endtask

    task automatic run_cmp(input int d, input logic [15:0] a, input logic [15:0] b,
                           input logic s, input string tag);
        int         c, lat;
        logic [2:0] e;
        lat = exp_latency(d, a, b);
        e   = exp_result(d, a, b, s);
        @(negedge clk);
        st[d] = 1'b1;
        sm[d] = s;
        av[d] = a;
        bv[d] = b;
        @(posedge clk);
        #1;
        chk($sformatf("%s.busy", tag), 32'(by[d]), 32'd1);
        chk($sformatf("%s.hold", tag), 32'({gt[d], lt[d], eq[d]}), 32'({pg[d], pl[d], pe[d]}));
        @(negedge clk);
        st[d] = 1'b0;
        av[d] = 16'($urandom);
        bv[d] = 16'($urandom);
        sm[d] = 1'($urandom);
        wait_done(d, tag, c);
        chk($sformatf("%s.lat", tag), 32'(c), 32'(lat));
        chk($sformatf("%s.gse", tag), 32'({gt[d], lt[d], eq[d]}), 32'(e));
        chk($sformatf("%s.busy_at_done", tag), 32'(by[d]), 32'd0);
        {pg[d], pl[d], pe[d]} = e;
        @(posedge clk);
        #1;
        chk($sformatf("%s.pulse", tag), 32'(dn[d]), 32'd0);
    endtask

    initial begin
        rst_n = 1'b1;
        for (int d = 0; d < 3; d++) begin
            st[d] = 1'b0; sm[d] = 1'b0; av[d] = '0; bv[d] = '0;
            pg[d] = 1'b0; pl[d] = 1'b0; pe[d] = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset%0d", d), 32'({by[d], dn[d], gt[d], lt[d], eq[d]}), 32'd0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases on the 16/2 instance.
        run_cmp(0, 16'h8000, 16'h7FFF, 1'b0, "u_8000_7fff");
        run_cmp(0, 16'hBEEF, 16'hBEEF, 1'b0, "u_beef_eq");
        run_cmp(0, 16'h0001, 16'h0002, 1'b0, "u_1_2");
        run_cmp(0, 16'h8000, 16'h0001, 1'b1, "s_8000_1");
        run_cmp(0, 16'h8000, 16'h0001, 1'b0, "u_8000_1");
        run_cmp(0, 16'hFFFF, 16'hFFFE, 1'b1, "s_m1_m2");

        // Back-to-back with start held high; operands scrambled while busy.
        @(negedge clk);
        st[0] = 1'b1;
        sm[0] = 1'b0;
        av[0] = b2b_a[0];
        bv[0] = b2b_b[0];
        for (int i = 0; i < 3; i++) begin
            int c;
            @(posedge clk);
            #1;
            chk($sformatf("b2b%0d.busy", i), 32'(by[0]), 32'd1);
            av[0] = 16'($urandom);
            bv[0] = 16'($urandom);
            wait_done(0, $sformatf("b2b%0d", i), c);
            chk($sformatf("b2b%0d.lat", i), 32'(c), 32'(exp_latency(0, b2b_a[i], b2b_b[i])));
            chk($sformatf("b2b%0d.gse", i), 32'({gt[0], lt[0], eq[0]}),
                32'(exp_result(0, b2b_a[i], b2b_b[i], 1'b0)));
            chk($sformatf("b2b%0d.busy_at_done", i), 32'(by[0]), 32'd0);
            {pg[0], pl[0], pe[0]} = exp_result(0, b2b_a[i], b2b_b[i], 1'b0);
            if (i < 2) begin
                av[0] = b2b_a[i + 1];
                bv[0] = b2b_b[i + 1];
            end else begin
                st[0] = 1'b0;
            end
        end
        begin
            int extra;
            extra = 0;
            repeat (10) begin
                @(posedge clk);
                #1;
                if (dn[0]) extra++;
            end
            chk("b2b.extra_done", 32'(extra), 32'd0);
        end

        // Reset in the middle of an all-equal 8-slice compare.
        @(negedge clk);
        st[0] = 1'b1;
        av[0] = 16'h1234;
        bv[0] = 16'h1234;
        @(posedge clk);
        @(negedge clk);
        st[0] = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst.outs", 32'({by[0], dn[0], gt[0], lt[0], eq[0]}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int extra;
            extra = 0;
            repeat (12) begin
                @(posedge clk);
                #1;
                if (dn[0]) extra++;
            end
            chk("midrst.no_done", 32'(extra), 32'd0);
        end
        for (int d = 0; d < 3; d++) begin
            pg[d] = 1'b0; pl[d] = 1'b0; pe[d] = 1'b0;
        end
        run_cmp(0, 16'h00F0, 16'h00E0, 1'b0, "post_rst");

        // Randomized operands on every geometry, biased toward shared prefixes.
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 15; i++) begin
                logic [15:0] a, b, mask;
                int          w, sel;
                w    = width_of(d);
                mask = 16'((32'd1 << w) - 1);
                a    = 16'($urandom) & mask;
                sel  = $urandom_range(0, 3);
                if (sel == 0)      b = a;
                else if (sel == 1) b = 16'($urandom) & mask;
                else               b = a ^ 16'(32'd1 << $urandom_range(0, w - 1));
                run_cmp(d, a, b, 1'($urandom), $sformatf("rnd%0d_%0d", d, i));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
